gpio_ctrl: RTL and testbench

//  16-pin GPIO interrupt controller. Synchronises the asynchronous gpio_pins bus.

---
 rtl/gpio_ctrl.sv | 59 +++++
 tb/tb_gpio_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: synchronised 16-pin GPIO with INT0/INT1 edge/level interrupts and a pin-change IRQ.
// Warm-up after reset suppresses false edges from pins already high at reset exit.
module gpio_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int INT0_PIN    = 14,
  parameter int INT1_PIN    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] interrupt_mask,
  input  logic [15:0] pinchange_msk,
  input  logic [15:0] gpio_pins,
  output logic        irq_int0,
  output logic        irq_int1,
  output logic        irq_pinchange
);
  localparam int WARM = SYNC_STAGES + 1;
  localparam int CW   = $clog2(WARM + 1);
  logic [15:0]   sync_q [SYNC_STAGES];
  logic [15:0]   s, p_q;
  logic [CW-1:0] warm_q, warm_d;
  logic          done, int0_d, int1_d, pc_d, int0_q, int1_q, pc_q;
  logic          unused_ok;
  // sense: 00 rise, 01 fall, 10 any edge, 11 low level
  function automatic logic sel(input logic [1:0] sense, input logic cur, input logic prev);
    return sense == 2'b00 ? cur & ~prev :
           sense == 2'b01 ? ~cur & prev :
           sense == 2'b10 ? cur ^ prev  : ~cur;
  endfunction
  always_comb begin
    s      = sync_q[SYNC_STAGES-1];
    done   = warm_q == CW'(WARM);
    warm_d = done ? warm_q : warm_q + 1'b1;
    int0_d = done & interrupt_mask[0] & sel(interrupt_mask[3:2], s[INT0_PIN], p_q[INT0_PIN]);
    int1_d = done & interrupt_mask[1] & sel(interrupt_mask[5:4], s[INT1_PIN], p_q[INT1_PIN]);
    pc_d   = done & |((s ^ p_q) & pinchange_msk);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      p_q    <= '0;
      warm_q <= '0;
      int0_q <= 1'b0;
      int1_q <= 1'b0;
      pc_q   <= 1'b0;
    end else begin
      sync_q[0] <= gpio_pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      p_q    <= s;
      warm_q <= warm_d;
      int0_q <= int0_d;
      int1_q <= int1_d;
      pc_q   <= pc_d;
    end
  assign irq_int0      = int0_q;
  assign irq_int1      = int1_q;
  assign irq_pinchange = pc_q;
  assign unused_ok     = ^interrupt_mask[31:6];
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed and random checks of gpio_ctrl against a pin-history latency model.
module tb_gpio_ctrl;
  localparam int S = 2;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] interrupt_mask = '0;
  logic [15:0] pinchange_msk = '0, gpio_pins = '0;
  logic        irq_int0, irq_int1, irq_pinchange;
  int          n_vec = 0, n_err = 0, k = 0;
  logic [15:0] hist [0:4095];
  logic [2:0]  exp_irq;

  always #5 clk = ~clk;

  gpio_ctrl dut (
    .clk(clk), .reset(reset), .interrupt_mask(interrupt_mask), .pinchange_msk(pinchange_msk),
    .gpio_pins(gpio_pins), .irq_int0(irq_int0), .irq_int1(irq_int1), .irq_pinchange(irq_pinchange)
  );

  function automatic logic sense_hit(input logic [1:0] sn, input logic cur, input logic prev);
    case (sn)
      2'b00:   return cur && !prev;
      2'b01:   return !cur && prev;
      2'b10:   return cur != prev;
      default: return !cur;
    endcase
  endfunction

  // Output after edge k reflects pins seen at edges k-S (now) and k-S-1 (before).
  task automatic cyc(input logic [15:0] pins, input logic [31:0] im, input logic [15:0] pm);
    logic [15:0] cur, prev;
    gpio_pins = pins; interrupt_mask = im; pinchange_msk = pm;
    @(posedge clk);
    if (k < 4095) k++;
    hist[k] = pins;
    exp_irq = '0;
    if (k >= S + 2) begin
      cur  = hist[k-S];
      prev = hist[k-S-1];
      exp_irq = {im[0] & sense_hit(im[3:2], cur[14], prev[14]),
                 im[1] & sense_hit(im[5:4], cur[15], prev[15]),
                 |((cur ^ prev) & pm)};
    end
    #1;
  endtask

  task automatic apply_reset(input logic [15:0] pins);
    @(negedge clk);
    reset = 1'b1; gpio_pins = pins;
    repeat (2) @(negedge clk);
    reset = 1'b0; k = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; gpio_pins = 16'hFFFF; interrupt_mask = 32'h3; pinchange_msk = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({irq_int0, irq_int1, irq_pinchange} !== 3'b000) begin
        n_err++; $display("FAIL reset_hold cyc %0d: got %b want 000", i, {irq_int0, irq_int1, irq_pinchange});
      end
    end
    @(negedge clk);
    reset = 1'b0; k = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(16'hFFFF, 32'h3, 16'hFFFF);
      n_vec++;
      if ({irq_int0, irq_int1, irq_pinchange} !== exp_irq || exp_irq !== 3'b000) begin
        n_err++; $display("FAIL reset_warmup cyc %0d: got %b want 000", i, {irq_int0, irq_int1, irq_pinchange});
      end
    end
  endtask

  task automatic test_int0_rise;
    logic [15:0] seq [12] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4000,
                              16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    apply_reset(16'h0);
    for (int i = 0; i < 12; i++) begin
      cyc(seq[i], 32'h1, 16'h4000);
      n_vec++;
      if ({irq_int0, irq_int1, irq_pinchange} !== exp_irq) begin
        n_err++; $display("FAIL int0_rise cyc %0d: got %b want %b", i, {irq_int0, irq_int1, irq_pinchange}, exp_irq);
      end
    end
  endtask

  task automatic test_int1_fall;
    logic [15:0] seq [12] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h8000,
                              16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    apply_reset(16'h0);
    for (int i = 0; i < 12; i++) begin
      cyc(seq[i], 32'h12, 16'h8000);
      n_vec++;
      if ({irq_int0, irq_int1, irq_pinchange} !== exp_irq) begin
        n_err++; $display("FAIL int1_fall cyc %0d: got %b want %b", i, {irq_int0, irq_int1, irq_pinchange}, exp_irq);
      end
    end
  endtask

  task automatic test_multi;
    logic [15:0] seq [10] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hAAAA, 16'h5555,
                              16'h5555, 16'h5555, 16'h5555, 16'h5555};
    apply_reset(16'h0);
    for (int i = 0; i < 10; i++) begin
      cyc(seq[i], 32'h23, 16'hFFFF);
      n_vec++;
      if ({irq_int0, irq_int1, irq_pinchange} !== exp_irq) begin
        n_err++; $display("FAIL multi_pin cyc %0d: got %b want %b", i, {irq_int0, irq_int1, irq_pinchange}, exp_irq);
      end
    end
  endtask

  task automatic test_level;
    apply_reset(16'h0);
    for (int i = 0; i < 14; i++) begin
      cyc(i < 8 ? 16'h0 : 16'h4000, 32'hD, 16'h0);
      n_vec++;
      if ({irq_int0, irq_int1, irq_pinchange} !== exp_irq) begin
        n_err++; $display("FAIL level_low cyc %0d: got %b want %b", i, {irq_int0, irq_int1, irq_pinchange}, exp_irq);
      end
    end
  endtask

  task automatic test_reset_mid;
    apply_reset(16'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(16'($urandom), 32'h0, 16'h0);
      n_vec++;
      if ({irq_int0, irq_int1, irq_pinchange} !== exp_irq) begin
        n_err++; $display("FAIL masked_off cyc %0d: got %b want %b", i, {irq_int0, irq_int1, irq_pinchange}, exp_irq);
      end
    end
    for (int i = 0; i < 6; i++) begin
      cyc(i < 4 ? 16'h0 : 16'hBFFF, 32'hD, 16'hFFFF);
      n_vec++;
      if ({irq_int0, irq_int1, irq_pinchange} !== exp_irq) begin
        n_err++; $display("FAIL pre_reset cyc %0d: got %b want %b", i, {irq_int0, irq_int1, irq_pinchange}, exp_irq);
      end
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({irq_int0, irq_int1, irq_pinchange} !== 3'b000) begin
      n_err++; $display("FAIL async_reset: got %b want 000", {irq_int0, irq_int1, irq_pinchange});
    end
    apply_reset(16'hBFFF);
    for (int i = 0; i < 8; i++) begin
      cyc(16'hBFFF, 32'hD, 16'hFFFF);
      n_vec++;
      if ({irq_int0, irq_int1, irq_pinchange} !== exp_irq) begin
        n_err++; $display("FAIL post_reset cyc %0d: got %b want %b", i, {irq_int0, irq_int1, irq_pinchange}, exp_irq);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] pins, pm;
    logic [31:0] im;
    pins = 16'($urandom);
    pm   = 16'($urandom);
    im   = $urandom;
    apply_reset(pins);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) pins = 16'($urandom);
      else if ($urandom_range(0, 1) == 0) pins = pins ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) pm = 16'($urandom);
      if ($urandom_range(0, 7) == 0) im = $urandom;
      cyc(pins, im, pm);
      n_vec++;
      if ({irq_int0, irq_int1, irq_pinchange} !== exp_irq) begin
        n_err++; $display("FAIL random cyc %0d: got %b want %b", i, {irq_int0, irq_int1, irq_pinchange}, exp_irq);
      end
    end
  endtask

  initial begin
    test_reset;
    test_int0_rise;
    test_int1_fall;
    test_multi;
    test_level;
    test_reset_mid;
    test_random;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
